// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The producer/consumer side uses the master modport and the adder uses the slave modport.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             Cout;
    logic             V;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, F, Cout, V
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, F, Cout, V
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage computes one S-bit slice, and the
// carry between slices is registered. A single global advance enable gives valid/ready backpressure.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned GROUP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_cla_adder_if.slave   bus
);
    localparam int unsigned S    = WIDTH / STAGES;
    localparam int unsigned NGRP = S / GROUP;

    if (WIDTH < 2 || STAGES < 1 || GROUP < 1 || (WIDTH % STAGES) != 0 || (S % GROUP) != 0)
    begin : g_bad_params
        $error("pipelined_cla_adder: illegal WIDTH/STAGES/GROUP combination");
    end

    // One S-bit slice: group generate/propagate, flat lookahead across groups and inside each group.
    function automatic logic [S:0] cla_slice(input logic [S-1:0] a, input logic [S-1:0] b,
                                             input logic ci);
        logic [S-1:0]    g, p, sum;
        logic [NGRP-1:0] gg, gp;
        logic [NGRP:0]   gc;
        logic            term, c;
        g   = a & b;
        p   = a ^ b;
        sum = '0;
        gg  = '0;
        gp  = '0;
        gc  = '0;
        c   = 1'b0;
        for (int j = 0; j < int'(NGRP); j++) begin
            for (int i = 0; i < int'(GROUP); i++) begin
                term = g[j*GROUP+i];
                for (int l = i + 1; l < int'(GROUP); l++) term &= p[j*GROUP+l];
                gg[j] |= term;
            end
            gp[j] = &p[j*GROUP +: GROUP];
        end
        for (int j = 0; j <= int'(NGRP); j++) begin
            term = ci;
            for (int l = 0; l < j; l++) term &= gp[l];
            gc[j] = term;
            for (int m = 0; m < j; m++) begin
                term = gg[m];
                for (int l = m + 1; l < j; l++) term &= gp[l];
                gc[j] |= term;
            end
        end
        for (int j = 0; j < int'(NGRP); j++) begin
            for (int i = 0; i < int'(GROUP); i++) begin
                term = gc[j];
                for (int l = 0; l < i; l++) term &= p[j*GROUP+l];
                c = term;
                for (int m = 0; m < i; m++) begin
                    term = g[j*GROUP+m];
                    for (int l = m + 1; l < i; l++) term &= p[j*GROUP+l];
                    c |= term;
                end
                sum[j*GROUP+i] = p[j*GROUP+i] ^ c;
            end
        end
        return {gc[NGRP], sum};
    endfunction

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] f_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             vld_q [STAGES];

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] f_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             vld_d [STAGES];

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_f [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];
    logic [S:0]       res   [STAGES];

    logic adv;

    assign adv          = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = rst_n && adv;

    // Stage 0 takes the (possibly inverted) operands; later stages take the previous rank.
    always_comb begin
        src_a[0] = bus.A;
        src_b[0] = bus.Sub ? ~bus.B : bus.B;
        src_f[0] = '0;
        src_c[0] = bus.Sub ? ~bus.Cin : bus.Cin;
        src_v[0] = bus.in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_f[k] = f_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = vld_q[k-1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            res[k]   = cla_slice(S'(src_a[k] >> (k*S)), S'(src_b[k] >> (k*S)), src_c[k]);
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            f_d[k]   = src_f[k] | (WIDTH'(res[k][S-1:0]) << (k*S));
            c_d[k]   = res[k][S];
            v_d[k]   = (src_a[k][WIDTH-1] == src_b[k][WIDTH-1]) &&
                       (res[k][S-1] != src_a[k][WIDTH-1]);
            vld_d[k] = src_v[k];
        end
    end

    // All ranks advance together or hold together; bubbles are kept in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                f_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                vld_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                f_q[k]   <= f_d[k];
                c_q[k]   <= c_d[k];
                v_q[k]   <= v_d[k];
                vld_q[k] <= vld_d[k];
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.F         = f_q[STAGES-1];
    assign bus.Cout      = c_q[STAGES-1];
    assign bus.V         = v_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors on 4-, 1- and 8-stage builds, randomized
// backpressure traffic against an arithmetic reference, and mid-pipeline reset.
module tb_pipelined_cla_adder;
    logic clk;
    logic rst_n;
    logic [31:0] a, b;
    logic cin, sub;
    logic iv4, ordy4, iv_s;

    int nchk;
    int nerr;

    pipelined_cla_adder_if #(.WIDTH(32)) if4 ();
    pipelined_cla_adder_if #(.WIDTH(32)) if1 ();
    pipelined_cla_adder_if #(.WIDTH(32)) if8 ();

    assign if4.A = a;  assign if4.B = b;  assign if4.Cin = cin;  assign if4.Sub = sub;
    assign if1.A = a;  assign if1.B = b;  assign if1.Cin = cin;  assign if1.Sub = sub;
    assign if8.A = a;  assign if8.B = b;  assign if8.Cin = cin;  assign if8.Sub = sub;
    assign if4.in_valid = iv4;   assign if4.out_ready = ordy4;
    assign if1.in_valid = iv_s;  assign if1.out_ready = 1'b1;
    assign if8.in_valid = iv_s;  assign if8.out_ready = 1'b1;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(1), .GROUP(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(8), .GROUP(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] f;
        logic        cout, v;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic; returns {V, Cout, F}.
    function automatic logic [33:0] ref_add(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic rc, input logic rs);
        logic [31:0] bb;
        logic [32:0] s;
        logic        ov;
        bb = rs ? ~rb : rb;
        s  = {1'b0, ra} + {1'b0, bb} + 33'(rs ? !rc : rc);
        ov = (ra[31] == bb[31]) && (s[31] != ra[31]);
        return {ov, s};
    endfunction

    task automatic chk_at(input string nm, input int stg, input int j, input logic ov,
                          input logic [31:0] f, input logic co, input logic v, input int i);
        chk($sformatf("%s v%0d valid@%0d", nm, i, j), 64'(ov), 64'(j == stg));
        if (j == stg) begin
            chk($sformatf("%s v%0d F", nm, i), 64'(f), 64'(tv[i].f));
            chk($sformatf("%s v%0d Cout", nm, i), 64'(co), 64'(tv[i].cout));
            chk($sformatf("%s v%0d V", nm, i), 64'(v), 64'(tv[i].v));
        end
    endtask

    initial begin
        logic [33:0] expq[$];
        logic [33:0] e;
        logic [31:0] held_f;
        logic        held_c, held_v, hold_chk;
        int sent, got, cyc, stale;

        nchk = 0;
        nerr = 0;
        tv[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tv[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tv[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tv[3] = '{32'd100,       32'd50,        1'b0, 1'b1, 32'd50,        1'b1, 1'b0};
        tv[4] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tv[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tv[6] = '{32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0};
        tv[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[8] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};

        rst_n = 1'b0; iv4 = 1'b0; iv_s = 1'b0; ordy4 = 1'b1;
        a = 32'h0; b = 32'h0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid4", 64'(if4.out_valid), 64'd0);
        chk("reset out_valid1", 64'(if1.out_valid), 64'd0);
        chk("reset out_valid8", 64'(if8.out_valid), 64'd0);
        chk("reset F4", 64'(if4.F), 64'd0);
        chk("in_ready during reset", 64'(if4.in_ready), 64'd0);
        rst_n = 1'b1;
        #1 chk("in_ready after reset", 64'(if4.in_ready), 64'd1);

        // Directed vectors: one beat, then bubbles; each build must present it after exactly STAGES edges.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = tv[i].a; b = tv[i].b; cin = tv[i].cin; sub = tv[i].sub;
            iv4 = 1'b1; iv_s = 1'b1;
            @(negedge clk);
            iv4 = 1'b0; iv_s = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                if (j > 1) @(negedge clk);
                chk_at("S4", 4, j, if4.out_valid, if4.F, if4.Cout, if4.V, i);
                chk_at("S1", 1, j, if1.out_valid, if1.F, if1.Cout, if1.V, i);
                chk_at("S8", 8, j, if8.out_valid, if8.F, if8.Cout, if8.V, i);
            end
        end

        // Randomized traffic with pseudo-random backpressure on the 4-stage build.
        sent = 0; got = 0; cyc = 0; hold_chk = 1'b0;
        held_f = '0; held_c = 1'b0; held_v = 1'b0;
        while (got < 16 && cyc < 400) begin
            @(negedge clk);
            if (hold_chk) begin
                chk("stall F stable", 64'(if4.F), 64'(held_f));
                chk("stall Cout stable", 64'(if4.Cout), 64'(held_c));
                chk("stall V stable", 64'(if4.V), 64'(held_v));
            end
            iv4 = (sent < 16);
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            ordy4 = ($urandom_range(0, 9) < 6);
            #1;
            chk("in_ready rule", 64'(if4.in_ready), 64'(!if4.out_valid || ordy4));
            if (if4.out_valid && ordy4) begin
                if (expq.size() == 0) begin
                    chk("unexpected beat", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("rand beat%0d F", got), 64'(if4.F), 64'(e[31:0]));
                    chk($sformatf("rand beat%0d Cout", got), 64'(if4.Cout), 64'(e[32]));
                    chk($sformatf("rand beat%0d V", got), 64'(if4.V), 64'(e[33]));
                end
                got++;
            end
            hold_chk = if4.out_valid && !ordy4;
            held_f = if4.F; held_c = if4.Cout; held_v = if4.V;
            if (iv4 && if4.in_ready) begin
                expq.push_back(ref_add(a, b, cin, sub));
                sent++;
            end
            cyc++;
        end
        chk("rand beats delivered", 64'(got), 64'd16);

        // Drain, then load 3 beats behind a stalled consumer and reset mid-flight.
        @(negedge clk);
        iv4 = 1'b0; ordy4 = 1'b1; a = 32'h0F0F_1234; b = 32'h0101_0101; sub = 1'b0; cin = 1'b1;
        repeat (8) @(negedge clk);
        ordy4 = 1'b0; iv4 = 1'b1;
        repeat (3) @(negedge clk);
        iv4 = 1'b0;
        rst_n = 1'b0;
        #1 chk("in_ready forced low", 64'(if4.in_ready), 64'd0);
        @(negedge clk);
        chk("mid reset out_valid", 64'(if4.out_valid), 64'd0);
        chk("mid reset F", 64'(if4.F), 64'd0);
        chk("mid reset Cout", 64'(if4.Cout), 64'd0);
        chk("mid reset V", 64'(if4.V), 64'd0);
        rst_n = 1'b1;
        #1 chk("mid reset in_ready", 64'(if4.in_ready), 64'd1);
        ordy4 = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (if4.out_valid) stale++;
        end
        chk("no stale beats", 64'(stale), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
